// File: rtl/uart_pkg.sv
// Shared UART types and elaboration-time helpers for the frame transmitter.
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} uart_state_e;

  // Rounded clocks-per-bit divider.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-2 depth, show-ahead read data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_do;

  assign wr_ready = (count != (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign wr_en    = wr_valid & wr_ready;
  assign rd_do    = rd_en & ~empty;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_do) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/uart_frame_tx.sv
// Buffered UART transmitter: FIFO in front of a start/data/parity/stop/break FSM.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 1152000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          send_break,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(DIV + 1);
  localparam int BW  = $clog2(DATA_BITS + 5);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  uart_state_e          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] sh, sh_n, fifo_data;
  logic                 par_q, par_n, txd_n;
  logic                 pop, launch, tick, fifo_empty;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign tick = (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    sh_n    = sh;
    par_n   = par_q;
    txd_n   = uart_txd;
    pop     = 1'b0;
    launch  = 1'b0;
    if (state != IDLE && !tick) cnt_n = cnt - 1'b1;
    case (state)
      IDLE:  launch = 1'b1;
      START: if (tick) begin
        state_n = DATA;
        cnt_n   = RELOAD;
        bit_n   = '0;
        txd_n   = sh[0];
      end
      DATA: if (tick) begin
        cnt_n = RELOAD;
        if (bit_cnt == BW'(DATA_BITS - 1)) begin
          bit_n = '0;
          if (PARITY != PARITY_NONE) begin
            state_n = PAR;
            txd_n   = par_q;
          end else begin
            state_n = STOP;
            txd_n   = 1'b1;
          end
        end else begin
          bit_n = bit_cnt + 1'b1;
          sh_n  = sh >> 1;
          txd_n = sh[1];
        end
      end
      PAR: if (tick) begin
        state_n = STOP;
        cnt_n   = RELOAD;
        bit_n   = '0;
        txd_n   = 1'b1;
      end
      STOP: if (tick) begin
        if (bit_cnt == BW'(STOP_BITS - 1)) launch = 1'b1;
        else begin
          bit_n = bit_cnt + 1'b1;
          cnt_n = RELOAD;
        end
      end
      // DATA_BITS+4 low units, then one high unit before re-arbitrating.
      BREAK: if (tick) begin
        if (bit_cnt == BW'(DATA_BITS + 4)) launch = 1'b1;
        else begin
          bit_n = bit_cnt + 1'b1;
          cnt_n = RELOAD;
          if (bit_cnt == BW'(DATA_BITS + 3)) txd_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Arbitration runs straight out of STOP/BREAK so queued frames abut.
    if (launch) begin
      bit_n = '0;
      if (send_break) begin
        state_n = BREAK;
        cnt_n   = RELOAD;
        txd_n   = 1'b0;
      end else if (!fifo_empty) begin
        state_n = START;
        pop     = 1'b1;
        sh_n    = fifo_data;
        par_n   = (^fifo_data) ^ (PARITY == PARITY_ODD);
        cnt_n   = RELOAD;
        txd_n   = 1'b0;
      end else begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      par_q    <= 1'b0;
      uart_txd <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      sh       <= sh_n;
      par_q    <= par_n;
      uart_txd <= txd_n;
      busy     <= (state_n != IDLE);
    end
  end
endmodule
